// File: rtl/pipelined_adder_pkg.sv
// Shared constants and parameter helpers for the slice-pipelined adder family.
// Later pipelined blocks reuse the default slice width and stage derivation.
package pipelined_adder_pkg;

  localparam int DEFAULT_SLICE = 4;

  // Guard the division so an illegal SLICE still elaborates far enough to hit the error check.
  function automatic int calc_stages(input int width, input int slice);
    return (slice > 0 && width >= slice) ? width / slice : 1;
  endfunction

  function automatic bit slicing_legal(input int width, input int slice);
    return (slice > 0) && (width >= slice) && ((width % slice) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational SLICE-bit ripple-carry adder built from per-bit full adders.
module adder_slice #(
  parameter int SLICE = 4
) (
  input  logic             ci,
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  output logic [SLICE-1:0] s,
  output logic             co
);

  logic [SLICE:0] w_c;

  assign w_c[0] = ci;

  for (genvar i = 0; i < SLICE; i++) begin : g_bit
    assign s[i]     = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign co = w_c[SLICE];

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder split into SLICE-bit stages with a registered carry between stages,
// valid/ready handshake with a global stall, and optional unsigned saturation.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int SLICE    = DEFAULT_SLICE,
  parameter int SATURATE = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             sat
);

  localparam int STAGES = calc_stages(WIDTH, SLICE);
  localparam bit SAT_EN = (SATURATE != 0);

  if (!slicing_legal(WIDTH, SLICE)) begin : g_bad_params
    $error("pipelined_adder: WIDTH (%0d) must be a positive multiple of SLICE (%0d)",
           WIDTH, SLICE);
  end

  logic              r_valid [STAGES];
  logic              r_carry [STAGES];
  logic [WIDTH-1:0]  r_sum   [STAGES];
  logic [WIDTH-1:0]  r_a     [STAGES];
  logic [WIDTH-1:0]  r_b     [STAGES];
  logic              r_sat;
  logic [STAGES-1:0] w_co;
  logic              w_advance;

  // The whole pipe moves as one; an unconsumed result freezes every stage.
  assign w_advance = !r_valid[STAGES-1] || out_ready;
  assign in_ready  = w_advance;

  assign out_valid = r_valid[STAGES-1];
  assign sum       = r_sum[STAGES-1];
  assign co        = r_carry[STAGES-1];
  assign sat       = r_sat;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam bit LAST = (k == STAGES - 1);

    logic             w_v_in;
    logic             w_c_in;
    logic [WIDTH-1:0] w_a_in;
    logic [WIDTH-1:0] w_b_in;
    logic [WIDTH-1:0] w_sum_in;
    logic [WIDTH-1:0] w_sum_next;
    logic [SLICE-1:0] w_s;

    if (k == 0) begin : g_head
      assign w_v_in   = in_valid;
      assign w_c_in   = ci;
      assign w_a_in   = a;
      assign w_b_in   = b;
      assign w_sum_in = '0;
    end else begin : g_tail
      assign w_v_in   = r_valid[k-1];
      assign w_c_in   = r_carry[k-1];
      assign w_a_in   = r_a[k-1];
      assign w_b_in   = r_b[k-1];
      assign w_sum_in = r_sum[k-1];
    end

    // Operands travel pre-shifted, so every stage adds the low slice.
    adder_slice #(.SLICE(SLICE)) u_slice (
      .ci (w_c_in),
      .a  (w_a_in[SLICE-1:0]),
      .b  (w_b_in[SLICE-1:0]),
      .s  (w_s),
      .co (w_co[k])
    );

    always_comb begin
      // NOTE: assign a full default before any conditional update so no latch is inferred.
      w_sum_next                   = w_sum_in;
      w_sum_next[k*SLICE +: SLICE] = w_s;
      if (LAST && SAT_EN && w_co[k]) begin
        w_sum_next = '1;
      end
    end

    // NOTE: data registers are reset as well so sum reads 0 while reset is held.
    // NOTE: non-blocking assignments let every stage sample its predecessor's old value.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_valid[k] <= 1'b0;
        r_carry[k] <= 1'b0;
        r_sum[k]   <= '0;
        r_a[k]     <= '0;
        r_b[k]     <= '0;
      end else if (w_advance) begin
        r_valid[k] <= w_v_in;
        r_carry[k] <= w_co[k];
        r_sum[k]   <= w_sum_next;
        r_a[k]     <= w_a_in >> SLICE;
        r_b[k]     <= w_b_in >> SLICE;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sat <= 1'b0;
    end else if (w_advance) begin
      r_sat <= SAT_EN && w_co[STAGES-1];
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench: a wrapping and a saturating instance share one stimulus stream;
// the driver queues hand-computed results and a monitor pops them on each output transfer.
module tb_pipelined_adder;

  localparam int W  = 16;
  localparam int S  = 4;
  localparam int ST = W / S;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    int           issue;
    bit           lat;
  } exp_t;

  localparam logic [W-1:0] TA  [8] = '{16'h00FF, 16'h7FFF, 16'hFFFF, 16'h1234,
                                       16'h8000, 16'h0000, 16'hFFFF, 16'hA5A5};
  localparam logic [W-1:0] TB  [8] = '{16'h0001, 16'h8000, 16'h0001, 16'h4321,
                                       16'h8000, 16'h0000, 16'h0000, 16'h5A5A};
  localparam logic         TC  [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  localparam logic [W-1:0] TS  [8] = '{16'h0100, 16'h0000, 16'h0000, 16'h5556,
                                       16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
  localparam logic         TCO [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};

  logic         clock     = 1'b0;
  logic         reset_n   = 1'b0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b1;
  logic         ci        = 1'b0;
  logic [W-1:0] a         = '0;
  logic [W-1:0] b         = '0;

  logic         rdy_w, vld_w, co_w, sat_w;
  logic [W-1:0] sum_w;
  logic         rdy_s, vld_s, co_s, sat_s;
  logic [W-1:0] sum_s;

  int   cyc      = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  exp_t m_e;

  pipelined_adder #(.WIDTH(W), .SLICE(S), .SATURATE(0)) u_wrap (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (rdy_w),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (vld_w),
    .out_ready (out_ready),
    .sum       (sum_w),
    .co        (co_w),
    .sat       (sat_w)
  );

  pipelined_adder #(.WIDTH(W), .SLICE(S), .SATURATE(1)) u_sat (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (rdy_s),
    .a         (a),
    .b         (b),
    .ci        (ci),
    .out_valid (vld_s),
    .out_ready (out_ready),
    .sum       (sum_s),
    .co        (co_s),
    .sat       (sat_s)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; queues the expected result only if the op is accepted.
  task automatic drive(input bit v, input logic [W-1:0] aa, input logic [W-1:0] bb,
                       input logic cc, input logic [W-1:0] es, input logic ec,
                       input bit ordy, input bit lat);
    exp_t e;
    @(negedge clock);
    in_valid  = v;
    a         = aa;
    b         = bb;
    ci        = cc;
    out_ready = ordy;
    #1;
    if (v && rdy_w) begin
      e.sum   = es;
      e.co    = ec;
      e.issue = cyc;
      e.lat   = lat;
      q.push_back(e);
    end
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, '0, '0, 1'b0, '0, 1'b0, ordy, 1'b0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 40) begin
      idle(1'b1);
      n++;
    end
    idle(1'b1);
    check("drain_empty", q.size(), 0);
  endtask

  // Monitor: samples between the driver's updates and the next rising edge.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset_n && vld_w && out_ready) begin
        if (q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got sum %0h with no pending op (t=%0t)", sum_w, $time);
        end else begin
          m_e = q.pop_front();
          check("wrap_sum", sum_w, m_e.sum);
          check("wrap_co", co_w, m_e.co);
          check("wrap_sat", sat_w, 0);
          check("sat_valid", vld_s, 1);
          check("sat_sum", sum_s, m_e.co ? 16'hFFFF : m_e.sum);
          check("sat_co", co_s, m_e.co);
          check("sat_flag", sat_s, m_e.co);
          if (m_e.lat) check("latency", cyc - m_e.issue, ST);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int stale;
    logic [W-1:0] k16;

    #12;
    check("rst_out_valid", vld_w, 0);
    check("rst_sum", sum_w, 0);
    check("rst_co", co_w, 0);
    check("rst_sat_sum", sum_s, 0);
    check("rst_sat_flag", sat_s, 0);
    @(negedge clock);
    #3 reset_n = 1'b1;
    idle(1'b1);
    check("in_ready_after_reset", rdy_w, 1);
    check("out_valid_idle", vld_w, 0);

    // Directed vectors back-to-back, including full-width carry ripple cases.
    for (int i = 0; i < 8; i++) drive(1'b1, TA[i], TB[i], TC[i], TS[i], TCO[i], 1'b1, 1'b1);
    drain();

    // Eight consecutive ops: one result per cycle, in order.
    for (int i = 1; i <= 8; i++) begin
      k16 = 16'(i);
      drive(1'b1, k16, 16'(16'h1000 * k16), 1'b0, 16'(16'h1001 * k16), 1'b0, 1'b1, 1'b1);
    end
    drain();

    // Fill the pipe, then hold the output for three cycles.
    for (int k = 1; k <= 4; k++) begin
      k16 = 16'(k);
      drive(1'b1, 16'(16'h1000 + k16), 16'(16'h0100 * k16), 1'b0,
            16'(16'h1000 + 16'h0101 * k16), 1'b0, 1'b1, 1'b0);
    end
    for (int s = 0; s < 3; s++) begin
      drive(1'b1, 16'h1005, 16'h0500, 1'b0, 16'h1505, 1'b0, 1'b0, 1'b0);
      check("stall_in_ready", rdy_w, 0);
      check("stall_in_ready_sat", rdy_s, 0);
      check("stall_out_valid", vld_w, 1);
      check("stall_sum", sum_w, 16'h1101);
    end
    drive(1'b1, 16'h1005, 16'h0500, 1'b0, 16'h1505, 1'b0, 1'b1, 1'b0);
    drain();

    // Asynchronous reset mid-cycle with ops in flight.
    for (int k = 1; k <= 4; k++) begin
      k16 = 16'(k);
      drive(1'b1, 16'(16'h1111 * k16), 16'h0000, 1'b0, 16'(16'h1111 * k16), 1'b0, 1'b0, 1'b0);
    end
    @(negedge clock);
    in_valid  = 1'b0;
    out_ready = 1'b0;
    #1;
    check("pre_reset_valid", vld_w, 1);
    check("pre_reset_sum", sum_w, 16'h1111);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_valid", vld_w, 0);
    check("async_rst_sum", sum_w, 0);
    check("async_rst_co", co_w, 0);
    check("async_rst_sat_valid", vld_s, 0);
    check("async_rst_sat_sum", sum_s, 0);
    q.delete();
    @(negedge clock);
    #3 reset_n = 1'b1;
    stale = 0;
    for (int i = 0; i < 10; i++) begin
      idle(1'b1);
      if (vld_w || vld_s) stale++;
    end
    check("no_stale_results", stale, 0);

    // Alternating valid with all-ones operands: bubbles kept, carry-out on every op.
    for (int i = 0; i < 10; i++) begin
      drive((i % 2) == 0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
